multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control FSM for the lab processor. It latches each fetched opcode and sequences FETCH/DECODE/EXEC/MEM/WB over several clocks. Per state it emits the datapath control word (same field set and encodings as the single-cycle decoder) plus instruction-memory and data-memory handshakes. It adds wait-state handling, a bus watchdog, halt/resume, illegal-opcode trapping and a retired-instruction counter.

## Interface
- OPCODE_W, 6, opcode width (≥6). Any nonzero bit above bit 5 marks the opcode illegal.
- RET_W, 32, retired-instruction counter width.
- TIMEOUT, 16, max wait cycles on any memory handshake; 0 disables the watchdog.
- clk  in  1  clock. One clock domain.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  instruction opcode, valid when imem_ready=1 in FETCH.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data access completes this cycle.
- stall  in  1  freeze: state, counters and opcode_q hold; all pulse outputs forced 0.
- resume  in  1  leave HALT, return to FETCH.
- imem_req  out  1  instruction fetch request.
- ir_write, pc_inc  out  1  latch IR / PC+4, pulsed on fetch completion.
- DataPCSel, RegSelect, RegWrite, MemRead, MemWrite, MemtoReg, AdSel, unconditional  out  1  datapath controls.
- conditional, ALUop  out  3  datapath controls.
- ALUinSel  out  2  ALU operand select.
- pc_write  out  1  branch-target PC load strobe (EXEC only).
- halted, illegal_op, bus_error  out  1  status; illegal_op and bus_error are sticky.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- retired  out  RET_W  count of completed instructions; wraps modulo 2^RET_W.

## Operation
- FETCH: imem_req=1, waiting for imem_ready.
  - imem_ready=1: ir_write=pc_inc=1, opcode_q<=opcode, go to DECODE.
- DECODE: decode opcode_q.
  - halt (6'h3F) → HALT, halted=1.
  - NOP (6'h3E) → FETCH, retired++.
  - illegal → HALT, illegal_op=1.
  - anything else → EXEC.
- Legal opcodes: 0x00 R-type, 0x01–0x05 ALU-immediate, 0x06/0x2A lw, 0x07 sw, 0x08–0x0A conditional branch, 0x0B br, 0x0C–0x0E b/bcy/bncy, 0x0F bl, 0x3E, 0x3F.
- EXEC drives ALUinSel, ALUop, AdSel, unconditional and conditional with the established encodings:
  - R: ALUop=111, ALUinSel=00.
  - addi/compi/shll/shrl/shra: ALUop 000/100/001/010/011, ALUinSel=10.
  - lw/sw: ALUinSel=10.
  - bltz/bz/bnz: ALUinSel=01, conditional 001/010/011.
  - br: AdSel=unconditional=1.
  - b/bl: unconditional=1.
  - bcy/bncy: conditional 100/101.
- EXEC next state:
  - Branches (0x08–0x0E): pc_write=1, retired++, → FETCH.
  - lw/sw → MEM.
  - R/imm/bl → WB.
- MEM: MemRead (lw) or MemWrite (sw) held until dmem_ready.
  - sw completes: retired++, → FETCH.
  - lw completes: → WB.
- WB: RegWrite=1 for exactly one cycle; retired++; → FETCH.
  - MemtoReg=1 for R/imm, 0 for lw.
  - bl: DataPCSel=RegSelect=1, unconditional=1.
- Outside its owning state, every control output is 0.
- HALT: all controls 0, halted=1.
  - resume=1 → FETCH next cycle; halted, illegal_op and bus_error clear.
  - resume in any other state is ignored.
- Watchdog: a wait counter resets on entry to FETCH/MEM and increments each non-stalled cycle without ready.
  - Reaching TIMEOUT → HALT, bus_error=1, the access is abandoned, retired unchanged.
- stall has priority over every transition except reset.

## Timing
- Reset (held high):
  - state=FETCH, opcode_q=6'h3E, retired=0, wait counter=0.
  - All outputs 0, including imem_req, which is gated by reset.
  - First imem_req appears the cycle after reset deasserts.
- Latency with zero wait states:
  - Branch: 3 cycles.
  - R, imm, bl, sw: 4 cycles.
  - lw: 5 cycles.
  - NOP: 2 cycles.
  - halt: 2 cycles to reach HALT.
- Each wait cycle adds 1.
- Outputs are Moore, decoded from state and opcode_q. The ready-qualified pulses (ir_write, pc_inc) are the only combinational ready paths.
- Reset mid-instruction aborts the instruction: no RegWrite/MemWrite pulse, retired not incremented.
- A ready that arrives with stall=1 is ignored; the handshake must repeat.

## Test plan
- Reset, then addi (0x01) with imem_ready=1 throughout → states 0,1,2,4,0; RegWrite pulse in cycle 4; ALUinSel=10, ALUop=000 in EXEC; retired=1.
- lw (0x06) with dmem_ready arriving 3 cycles into MEM → MemRead high 4 cycles; MemtoReg=0 in WB; total 8 cycles; retired=1.
- bnz (0x0A) → pc_write=1 and conditional=011 in EXEC only; no RegWrite; 3 cycles.
- Opcode 0x20 → illegal_op=1, halted=1, state=5; then resume → FETCH with flags cleared.
- TIMEOUT=4, imem_ready held 0 → bus_error=1 after 4 cycles, state=HALT, retired unchanged.
- RET_W=2, run 5 NOPs → retired sequence 1,2,3,0,1; reset asserted in MEM of an sw → no MemWrite, retired=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the lab processor.
// Walks FETCH/DECODE/EXEC/MEM/WB, emits the datapath control word per state,
// and handles memory wait states, a bus watchdog, halt/resume, illegal-opcode
// trapping and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int RET_W    = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                stall,
    input  logic                resume,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                DataPCSel,
    output logic                RegSelect,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                AdSel,
    output logic                unconditional,
    output logic [2:0]          conditional,
    output logic [2:0]          ALUop,
    output logic [1:0]          ALUinSel,
    output logic                pc_write,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_error,
    output logic [2:0]          state,
    output logic [RET_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(6'h3E);
    localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(6'h3F);
    localparam logic                WD_EN     = (TIMEOUT > 0);
    localparam logic [31:0]         WAIT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic [RET_W-1:0]    RET_ONE   = RET_W'(1);

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [RET_W-1:0]      retired_q, retired_d;
    logic [31:0]           wait_q, wait_d;
    logic                  illegal_q, illegal_d;
    logic                  buserr_q, buserr_d;

    logic [5:0] op;
    logic       op_hi_zero;
    logic       is_lw, is_sw, is_branch, wd_expire;

    // Opcode legality: 0x00-0x0F, lw alias 0x2A, NOP and halt.
    function automatic logic op_legal(input logic [5:0] o);
        return (o <= 6'h0F) || (o == 6'h2A) || (o == 6'h3E) || (o == 6'h3F);
    endfunction

    assign op         = opcode_q[5:0];
    assign op_hi_zero = ((opcode_q >> 6) == '0);
    assign is_lw      = (op == 6'h06) || (op == 6'h2A);
    assign is_sw      = (op == 6'h07);
    assign is_branch  = (op >= 6'h08) && (op <= 6'h0E);
    assign wd_expire  = WD_EN && (wait_q == WAIT_LAST);

    // Next-state, counter and sticky-flag computation; stall freezes everything.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        buserr_d  = buserr_q;
        if (!stall) begin
            // Wait counter is zero in every non-waiting state, so FETCH/MEM start at 0.
            wait_d = '0;
            unique case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        opcode_d = opcode;
                        state_d  = S_DECODE;
                    end else if (wd_expire) begin
                        state_d  = S_HALT;
                        buserr_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    if (opcode_q == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (opcode_q == OP_NOP) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + RET_ONE;
                    end else if (!(op_hi_zero && op_legal(op))) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + RET_ONE;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_sw) begin
                            state_d   = S_FETCH;
                            retired_d = retired_q + RET_ONE;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wd_expire) begin
                        state_d  = S_HALT;
                        buserr_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + RET_ONE;
                end
                S_HALT: begin
                    if (resume) begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b0;
                        buserr_d  = 1'b0;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State register with synchronous reset; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= OP_NOP;
            retired_q <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            buserr_q  <= buserr_d;
        end
    end

    // Moore control decode from state and latched opcode; everything is zero under reset.
    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_inc        = 1'b0;
        DataPCSel     = 1'b0;
        RegSelect     = 1'b0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        AdSel         = 1'b0;
        unconditional = 1'b0;
        conditional   = 3'b000;
        ALUop         = 3'b000;
        ALUinSel      = 2'b00;
        pc_write      = 1'b0;
        halted        = 1'b0;
        illegal_op    = 1'b0;
        bus_error     = 1'b0;
        state         = 3'd0;
        retired       = '0;
        if (!reset) begin
            state      = state_q;
            retired    = retired_q;
            illegal_op = illegal_q;
            bus_error  = buserr_q;
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready && !stall;
                    pc_inc   = imem_ready && !stall;
                end
                S_EXEC: begin
                    pc_write = is_branch && !stall;
                    case (op)
                        6'h00: ALUop = 3'b111;
                        6'h01: begin ALUop = 3'b000; ALUinSel = 2'b10; end
                        6'h02: begin ALUop = 3'b100; ALUinSel = 2'b10; end
                        6'h03: begin ALUop = 3'b001; ALUinSel = 2'b10; end
                        6'h04: begin ALUop = 3'b010; ALUinSel = 2'b10; end
                        6'h05: begin ALUop = 3'b011; ALUinSel = 2'b10; end
                        6'h06, 6'h07, 6'h2A: ALUinSel = 2'b10;
                        6'h08: begin ALUinSel = 2'b01; conditional = 3'b001; end
                        6'h09: begin ALUinSel = 2'b01; conditional = 3'b010; end
                        6'h0A: begin ALUinSel = 2'b01; conditional = 3'b011; end
                        6'h0B: begin AdSel = 1'b1; unconditional = 1'b1; end
                        6'h0C, 6'h0F: unconditional = 1'b1;
                        6'h0D: conditional = 3'b100;
                        6'h0E: conditional = 3'b101;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                end
                S_WB: begin
                    RegWrite = !stall;
                    MemtoReg = (op <= 6'h05);
                    if (op == 6'h0F) begin
                        DataPCSel     = 1'b1;
                        RegSelect     = 1'b1;
                        unconditional = 1'b1;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (RET_W=2, TIMEOUT=4 so that
// counter wrap and the watchdog are reachable in a few cycles).
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset, imem_ready, dmem_ready, stall, resume;
    logic [5:0] opcode;
    logic       imem_req, ir_write, pc_inc;
    logic       DataPCSel, RegSelect, RegWrite, MemRead, MemWrite, MemtoReg, AdSel, unconditional;
    logic [2:0] conditional, ALUop;
    logic [1:0] ALUinSel;
    logic       pc_write, halted, illegal_op, bus_error;
    logic [2:0] state;
    logic [1:0] retired;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(6), .RET_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .stall(stall), .resume(resume),
        .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc),
        .DataPCSel(DataPCSel), .RegSelect(RegSelect), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .AdSel(AdSel), .unconditional(unconditional), .conditional(conditional),
        .ALUop(ALUop), .ALUinSel(ALUinSel), .pc_write(pc_write),
        .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error),
        .state(state), .retired(retired)
    );

    // ctl = {DataPCSel,RegSelect,RegWrite,MemRead,MemWrite,MemtoReg,AdSel,unconditional,
    //        conditional[2:0], ALUop[2:0], ALUinSel[1:0], pc_write}
    logic [16:0] ctl;
    logic [25:0] obs;
    assign ctl = {DataPCSel, RegSelect, RegWrite, MemRead, MemWrite, MemtoReg, AdSel,
                  unconditional, conditional, ALUop, ALUinSel, pc_write};
    // flags = {imem_req, ir_write, pc_inc, halted, illegal_op, bus_error}
    assign obs = {state, imem_req, ir_write, pc_inc, halted, illegal_op, bus_error, ctl};

    localparam logic [16:0] C0       = 17'd0;
    localparam logic [16:0] C_ADDI   = {8'b00000000, 3'b000, 3'b000, 2'b10, 1'b0};
    localparam logic [16:0] C_WB_ALU = {8'b00100100, 9'd0};
    localparam logic [16:0] C_MEMRD  = {8'b00010000, 9'd0};
    localparam logic [16:0] C_WB_LW  = {8'b00100000, 9'd0};
    localparam logic [16:0] C_BNZ    = {8'b00000000, 3'b011, 3'b000, 2'b01, 1'b1};
    localparam logic [16:0] C_BL_EX  = {8'b00000001, 9'd0};
    localparam logic [16:0] C_BL_WB  = {8'b11100001, 9'd0};
    localparam logic [16:0] C_MEMWR  = {8'b00001000, 9'd0};

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_WAIT  = 6'b100000;
    localparam logic [5:0] F_FETCH = 6'b111000;
    localparam logic [5:0] F_ILL   = 6'b000110;
    localparam logic [5:0] F_BUS   = 6'b000101;

    function automatic logic [25:0] ex(input logic [2:0] s, input logic [5:0] f, input logic [16:0] c);
        return {s, f, c};
    endfunction

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; stall = 1'b0; resume = 1'b0;
        opcode = 6'h01;
        @(negedge clk); #1;
        if (obs !== ex(3'd0, F_NONE, C0)) begin $display("FAIL reset_outputs got=%b want=%b", obs, ex(3'd0, F_NONE, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd0) begin $display("FAIL reset_retired got=%0d want=0", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_addi();
        @(negedge clk); reset = 1'b0; imem_ready = 1'b1; opcode = 6'h01; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL addi_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL addi_decode got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd2, F_NONE, C_ADDI)) begin $display("FAIL addi_exec got=%b want=%b", obs, ex(3'd2, F_NONE, C_ADDI)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd4, F_NONE, C_WB_ALU)) begin $display("FAIL addi_wb got=%b want=%b", obs, ex(3'd4, F_NONE, C_WB_ALU)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL addi_done got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd1) begin $display("FAIL addi_retired got=%0d want=1", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_lw();
        @(negedge clk); imem_ready = 1'b1; opcode = 6'h06; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL lw_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL lw_decode got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd2, F_NONE, C_ADDI)) begin $display("FAIL lw_exec got=%b want=%b", obs, ex(3'd2, F_NONE, C_ADDI)); n_fail++; end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); dmem_ready = (k == 3); #1;
            if (obs !== ex(3'd3, F_NONE, C_MEMRD)) begin $display("FAIL lw_mem%0d got=%b want=%b", k, obs, ex(3'd3, F_NONE, C_MEMRD)); n_fail++; end
            n_cmp++;
        end
        @(negedge clk); dmem_ready = 1'b0; #1;
        if (obs !== ex(3'd4, F_NONE, C_WB_LW)) begin $display("FAIL lw_wb got=%b want=%b", obs, ex(3'd4, F_NONE, C_WB_LW)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL lw_done got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd2) begin $display("FAIL lw_retired got=%0d want=2", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_bnz();
        @(negedge clk); imem_ready = 1'b1; opcode = 6'h0A; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL bnz_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL bnz_decode got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd2, F_NONE, C_BNZ)) begin $display("FAIL bnz_exec got=%b want=%b", obs, ex(3'd2, F_NONE, C_BNZ)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL bnz_done got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd3) begin $display("FAIL bnz_retired got=%0d want=3", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_illegal();
        @(negedge clk); imem_ready = 1'b1; opcode = 6'h20; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL ill_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL ill_decode got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd5, F_ILL, C0)) begin $display("FAIL ill_halt got=%b want=%b", obs, ex(3'd5, F_ILL, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd5, F_ILL, C0)) begin $display("FAIL ill_sticky got=%b want=%b", obs, ex(3'd5, F_ILL, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); resume = 1'b1; #1;
        if (obs !== ex(3'd5, F_ILL, C0)) begin $display("FAIL ill_resume_cycle got=%b want=%b", obs, ex(3'd5, F_ILL, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); resume = 1'b0; #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL ill_resumed got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd3) begin $display("FAIL ill_retired got=%0d want=3", retired); n_fail++; end
        n_cmp++;
    endtask

    // The FETCH cycle that closed the previous test is wait cycle 1 of 4.
    task automatic test_timeout();
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); #1;
            if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL tmo_wait%0d got=%b want=%b", k, obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
            n_cmp++;
        end
        @(negedge clk); #1;
        if (obs !== ex(3'd5, F_BUS, C0)) begin $display("FAIL tmo_halt got=%b want=%b", obs, ex(3'd5, F_BUS, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd3) begin $display("FAIL tmo_retired got=%0d want=3", retired); n_fail++; end
        n_cmp++;
        @(negedge clk); resume = 1'b1; #1;
        @(negedge clk); resume = 1'b0; #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL tmo_resumed got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_bl_stall();
        @(negedge clk); stall = 1'b1; imem_ready = 1'b1; opcode = 6'h0F; #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL stall_fetch got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); stall = 1'b0; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL bl_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; stall = 1'b1; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL bl_decode got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); stall = 1'b0; #1;
        if (obs !== ex(3'd1, F_NONE, C0)) begin $display("FAIL stall_hold got=%b want=%b", obs, ex(3'd1, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd2, F_NONE, C_BL_EX)) begin $display("FAIL bl_exec got=%b want=%b", obs, ex(3'd2, F_NONE, C_BL_EX)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (obs !== ex(3'd4, F_NONE, C_BL_WB)) begin $display("FAIL bl_wb got=%b want=%b", obs, ex(3'd4, F_NONE, C_BL_WB)); n_fail++; end
        n_cmp++;
        @(negedge clk); #1;
        if (retired !== 2'd0) begin $display("FAIL bl_retired_wrap got=%0d want=0", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_sw();
        @(negedge clk); imem_ready = 1'b1; opcode = 6'h07; #1;
        if (obs !== ex(3'd0, F_FETCH, C0)) begin $display("FAIL sw_fetch got=%b want=%b", obs, ex(3'd0, F_FETCH, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); imem_ready = 1'b0; #1;
        @(negedge clk); #1;
        if (obs !== ex(3'd2, F_NONE, C_ADDI)) begin $display("FAIL sw_exec got=%b want=%b", obs, ex(3'd2, F_NONE, C_ADDI)); n_fail++; end
        n_cmp++;
        @(negedge clk); dmem_ready = 1'b1; #1;
        if (obs !== ex(3'd3, F_NONE, C_MEMWR)) begin $display("FAIL sw_mem got=%b want=%b", obs, ex(3'd3, F_NONE, C_MEMWR)); n_fail++; end
        n_cmp++;
        @(negedge clk); dmem_ready = 1'b0; #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL sw_done got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd1) begin $display("FAIL sw_retired got=%0d want=1", retired); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_nop_wrap();
        logic [1:0] rexp [6];
        rexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(negedge clk); reset = 1'b1; imem_ready = 1'b0;
        @(negedge clk); reset = 1'b0; imem_ready = 1'b1; opcode = 6'h3E;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (state !== 3'd0 || retired !== rexp[i]) begin $display("FAIL nop%0d_fetch state=%0d retired=%0d want state=0 retired=%0d", i, state, retired, rexp[i]); n_fail++; end
            n_cmp++;
            @(negedge clk); #1;
            if (state !== 3'd1) begin $display("FAIL nop%0d_decode state=%0d want=1", i, state); n_fail++; end
            n_cmp++;
            @(negedge clk);
        end
        imem_ready = 1'b0; #1;
        if (obs !== ex(3'd0, F_WAIT, C0) || retired !== rexp[5]) begin $display("FAIL nop_wrap_end retired=%0d want=%0d obs=%b", retired, rexp[5], obs); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid_sw();
        @(negedge clk); imem_ready = 1'b1; opcode = 6'h07; #1;
        @(negedge clk); imem_ready = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        if (obs !== ex(3'd3, F_NONE, C_MEMWR)) begin $display("FAIL rst_sw_mem got=%b want=%b", obs, ex(3'd3, F_NONE, C_MEMWR)); n_fail++; end
        n_cmp++;
        @(negedge clk); reset = 1'b1; dmem_ready = 1'b1; #1;
        if (obs !== ex(3'd0, F_NONE, C0)) begin $display("FAIL rst_sw_gated got=%b want=%b", obs, ex(3'd0, F_NONE, C0)); n_fail++; end
        n_cmp++;
        @(negedge clk); dmem_ready = 1'b0; #1;
        @(negedge clk); reset = 1'b0; #1;
        if (obs !== ex(3'd0, F_WAIT, C0)) begin $display("FAIL rst_sw_after got=%b want=%b", obs, ex(3'd0, F_WAIT, C0)); n_fail++; end
        n_cmp++;
        if (retired !== 2'd0) begin $display("FAIL rst_sw_retired got=%0d want=0", retired); n_fail++; end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw();
        test_bnz();
        test_illegal();
        test_timeout();
        test_bl_stall();
        test_sw();
        test_nop_wrap();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
